ggc_bank: RTL and testbench

- Parametrised cheat-code substitution engine for the NES CPU bus. Successor to the fixed 8-slot engine.
- Holds SLOTS programmable codes. Each code has an address, a compare byte, a replace byte and a mode byte.
- New over the previous generation: per-slot mode (enable, compare on/off, full-address vs ROM-window match), saturating per-slot hit counters, and a PI readback port.
- Sits beside the PRG path. When a slot hits, the mapper muxes ggc_do onto the CPU data bus instead of prg_do.

---
 rtl/ggc_bank.sv | 144 ++++++++++++++
 tb/tb_ggc_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ggc_bank.sv
// Cheat-code substitution bank for the NES CPU bus: SLOTS programmable codes with
// per-slot mode, saturating hit counters and host (PI) readback.
module ggc_bank #(
  parameter int SLOTS = 16,
  parameter int DELAY = 4,
  parameter int HIT_W = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_pi_ce_ggc,
  input  logic [$clog2(SLOTS)+2:0]       i_pi_addr,
  input  logic                           i_pi_we,
  input  logic                           i_pi_act,
  input  logic [7:0]                     i_pi_dato,
  input  logic                           i_cpu_m2,
  input  logic                           i_cpu_rw,
  input  logic [15:0]                    i_cpu_addr,
  input  logic                           i_cheats_on,
  input  logic [7:0]                     i_prg_do,
  output logic [7:0]                     o_ggc_do,
  output logic                           o_ggc_ce_cpu,
  output logic [7:0]                     o_ggc_pi_do
);

  localparam int SW = $clog2(SLOTS);
  localparam int CW = $clog2(DELAY + 2);

  logic [SW-1:0]    w_sel;
  logic [2:0]       w_reg;
  logic             w_wr;
  logic             r_rd_st;
  logic [CW-1:0]    r_cnt;
  logic             w_rd_ok;
  logic [SLOTS-1:0] w_act;
  logic             w_any;
  logic [SW-1:0]    w_win;
  logic             w_inc;
  logic             r_hit_prev;

  logic [7:0]       w_lo   [SLOTS];
  logic [7:0]       w_hi   [SLOTS];
  logic [7:0]       w_cmp  [SLOTS];
  logic [7:0]       w_rep  [SLOTS];
  logic [2:0]       w_mode [SLOTS];
  logic [HIT_W-1:0] w_hits [SLOTS];

  assign w_sel   = i_pi_addr[SW+2:3];
  assign w_reg   = i_pi_addr[2:0];
  assign w_wr    = i_pi_ce_ggc & i_pi_we & i_pi_act;
  assign w_rd_ok = (r_cnt == CW'(DELAY));

  // Shared read-strobe qualifier: counts clocks since m2&rw was latched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_st    <= 1'b0;
      r_cnt      <= '0;
      r_hit_prev <= 1'b0;
    end else begin
      r_rd_st    <= i_cpu_m2 & i_cpu_rw;
      r_hit_prev <= w_any & i_cheats_on;
      if (!r_rd_st)
        r_cnt <= '0;
      else if (r_cnt < CW'(DELAY))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    logic [7:0]       r_lo, r_hi, r_cmp, r_rep;
    logic [2:0]       r_mode;
    logic [HIT_W-1:0] r_hits;
    logic             w_me, w_amatch, w_dmatch;

    assign w_me = w_wr && (w_sel == SW'(gi));

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_lo   <= '0;
        r_hi   <= '0;
        r_cmp  <= '0;
        r_rep  <= '0;
        r_mode <= '0;
      end else if (w_me) begin
        case (w_reg)
          3'd0:    r_lo   <= i_pi_dato;
          3'd1:    r_hi   <= i_pi_dato;
          3'd2:    r_cmp  <= i_pi_dato;
          3'd3:    r_rep  <= i_pi_dato;
          3'd4:    r_mode <= i_pi_dato[2:0];
          default: ;
        endcase
      end
    end

    // A host clear beats a same-clock increment.
    always_ff @(posedge i_clk) begin
      if (i_rst)
        r_hits <= '0;
      else if (w_me && w_reg == 3'd5)
        r_hits <= '0;
      else if (w_inc && w_win == SW'(gi) && r_hits != {HIT_W{1'b1}})
        r_hits <= r_hits + 1'b1;
    end

    assign w_amatch = r_mode[2] ? (i_cpu_addr == {r_hi, r_lo})
                                : ({1'b1, i_cpu_addr[14:0]} == {r_hi, r_lo});
    assign w_dmatch = !r_mode[1] || (i_prg_do == r_cmp);
    assign w_act[gi] = r_mode[0] & w_amatch & w_dmatch & i_cpu_m2 & i_cpu_rw & w_rd_ok;

    assign w_lo[gi]   = r_lo;
    assign w_hi[gi]   = r_hi;
    assign w_cmp[gi]  = r_cmp;
    assign w_rep[gi]  = r_rep;
    assign w_mode[gi] = r_mode;
    assign w_hits[gi] = r_hits;
  end

  always_comb begin
    w_win = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (w_act[i]) w_win = SW'(i);
  end

  assign w_any        = |w_act;
  assign w_inc        = w_any & i_cheats_on & ~r_hit_prev;
  assign o_ggc_ce_cpu = w_any & i_cheats_on;
  assign o_ggc_do     = w_any ? w_rep[w_win] : 8'h00;

  always_comb begin
    o_ggc_pi_do = 8'h00;
    if (i_pi_ce_ggc) begin
      case (w_reg)
        3'd0:    o_ggc_pi_do = w_lo[w_sel];
        3'd1:    o_ggc_pi_do = w_hi[w_sel];
        3'd2:    o_ggc_pi_do = w_cmp[w_sel];
        3'd3:    o_ggc_pi_do = w_rep[w_sel];
        3'd4:    o_ggc_pi_do = {5'b0, w_mode[w_sel]};
        3'd5:    o_ggc_pi_do = 8'(w_hits[w_sel]);
        default: o_ggc_pi_do = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_ggc_bank.sv
// Directed bench for ggc_bank: programs slots over PI, drives CPU reads and
// checks substitution timing, priority, counters and reset behaviour.
module tb_ggc_bank;
  localparam int SLOTS = 16;
  localparam int DELAY = 4;
  localparam int HIT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pi_ce, pi_we, pi_act;
  logic [6:0]  pi_addr;
  logic [7:0]  pi_dato;
  logic        m2, rw;
  logic [15:0] cpu_addr;
  logic        cheats_on;
  logic [7:0]  prg_do;
  logic [7:0]  ggc_do;
  logic        ggc_ce;
  logic [7:0]  pi_do;

  int checks = 0;
  int errors = 0;

  ggc_bank #(.SLOTS(SLOTS), .DELAY(DELAY), .HIT_W(HIT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pi_ce_ggc(pi_ce), .i_pi_addr(pi_addr), .i_pi_we(pi_we), .i_pi_act(pi_act),
    .i_pi_dato(pi_dato),
    .i_cpu_m2(m2), .i_cpu_rw(rw), .i_cpu_addr(cpu_addr),
    .i_cheats_on(cheats_on), .i_prg_do(prg_do),
    .o_ggc_do(ggc_do), .o_ggc_ce_cpu(ggc_ce), .o_ggc_pi_do(pi_do)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pi_wr(input int slot, input int rg, input logic [7:0] d);
    pi_ce = 1'b1; pi_we = 1'b1; pi_act = 1'b1;
    pi_addr = 7'(slot * 8 + rg); pi_dato = d;
    tick();
    pi_ce = 1'b0; pi_we = 1'b0; pi_act = 1'b0;
  endtask

  task automatic pi_rd(input string tag, input int slot, input int rg, input logic [7:0] exp);
    pi_ce = 1'b1; pi_we = 1'b0; pi_addr = 7'(slot * 8 + rg);
    #1;
    chk(tag, pi_do, exp);
    pi_ce = 1'b0;
    #1;
  endtask

  task automatic prog(input int slot, input logic [15:0] a, input logic [7:0] c,
                      input logic [7:0] r, input logic [7:0] md);
    pi_wr(slot, 0, a[7:0]);
    pi_wr(slot, 1, a[15:8]);
    pi_wr(slot, 2, c);
    pi_wr(slot, 3, r);
    pi_wr(slot, 4, md);
  endtask

  // Holds m2&rw for DELAY+3 clocks, then idles two clocks so the qualifier resets.
  task automatic cpu_read(input logic [15:0] a, input logic [7:0] p, input logic exp_ce,
                          input logic [7:0] exp_do, input string tag, input bit do_chk);
    cpu_addr = a; prg_do = p; m2 = 1'b1; rw = 1'b1;
    repeat (DELAY) tick();
    if (do_chk) chk({tag, "_early"}, {7'b0, ggc_ce}, 8'h00);
    tick();
    if (do_chk) begin
      chk({tag, "_ce"}, {7'b0, ggc_ce}, {7'b0, exp_ce});
      chk({tag, "_do"}, ggc_do, exp_do);
    end
    repeat (2) tick();
    m2 = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; pi_ce = 1'b0; pi_we = 1'b0; pi_act = 1'b0; pi_addr = '0; pi_dato = '0;
    m2 = 1'b0; rw = 1'b0; cpu_addr = '0; cheats_on = 1'b1; prg_do = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ce", {7'b0, ggc_ce}, 8'h00);
    chk("rst_do", ggc_do, 8'h00);
    chk("rst_pido", pi_do, 8'h00);

    // Reset state: nothing substitutes, all slot registers read 0.
    cpu_addr = 16'h8123; m2 = 1'b1; rw = 1'b1;
    repeat (8) tick();
    chk("idle_ce", {7'b0, ggc_ce}, 8'h00);
    chk("idle_do", ggc_do, 8'h00);
    m2 = 1'b0; repeat (2) tick();
    for (int r = 0; r < 8; r++) pi_rd($sformatf("rst_s3_r%0d", r), 3, r, 8'h00);

    // Slot 3: window match at $A123, one count per read.
    prog(3, 16'hA123, 8'h00, 8'hEA, 8'h01);
    pi_rd("s3_lo", 3, 0, 8'h23);
    pi_rd("s3_hi", 3, 1, 8'hA1);
    pi_rd("s3_mode", 3, 4, 8'h01);
    cpu_read(16'hA123, 8'h00, 1'b1, 8'hEA, "s3_rd1", 1'b1);
    pi_rd("s3_hit1", 3, 5, 8'd1);
    cpu_read(16'hA123, 8'h00, 1'b1, 8'hEA, "s3_rd2", 1'b1);
    pi_rd("s3_hit2", 3, 5, 8'd2);

    // Slot 2: compare byte gate.
    prog(2, 16'h8010, 8'h55, 8'hAA, 8'h03);
    cpu_read(16'h8010, 8'h55, 1'b1, 8'hAA, "s2_cmp_ok", 1'b1);
    pi_rd("s2_hit1", 2, 5, 8'd1);
    cpu_read(16'h8010, 8'h54, 1'b0, 8'h00, "s2_cmp_bad", 1'b1);
    pi_rd("s2_hit_hold", 2, 5, 8'd1);

    // Slots 1 and 5 collide: lowest index wins and alone counts.
    prog(1, 16'hC000, 8'h00, 8'h11, 8'h01);
    prog(5, 16'hC000, 8'h00, 8'h22, 8'h01);
    cpu_read(16'hC000, 8'h00, 1'b1, 8'h11, "prio", 1'b1);
    pi_rd("prio_hit1", 1, 5, 8'd1);
    pi_rd("prio_hit5", 5, 5, 8'd0);

    // Slot 6: full-address vs window matching at $6000.
    prog(6, 16'h6000, 8'h00, 8'h66, 8'h05);
    cpu_read(16'h6000, 8'h00, 1'b1, 8'h66, "full_6000", 1'b1);
    pi_wr(6, 4, 8'h01);
    cpu_read(16'h6000, 8'h00, 1'b0, 8'h00, "win_6000", 1'b1);
    cpu_read(16'hE000, 8'h00, 1'b0, 8'h00, "win_E000", 1'b1);

    // Saturation of slot 3's counter.
    for (int n = 0; n < 253; n++) cpu_read(16'hA123, 8'h00, 1'b1, 8'hEA, "sat", 1'b0);
    pi_rd("sat_255", 3, 5, 8'd255);
    cpu_read(16'hA123, 8'h00, 1'b1, 8'hEA, "sat_rd", 1'b1);
    pi_rd("sat_hold", 3, 5, 8'd255);

    // Clear write on the same edge as the increment.
    cpu_addr = 16'hA123; m2 = 1'b1; rw = 1'b1;
    repeat (DELAY + 1) tick();
    chk("clr_ce", {7'b0, ggc_ce}, 8'h01);
    pi_wr(3, 5, 8'hFF);
    pi_rd("clr_wins", 3, 5, 8'd0);
    repeat (2) tick();
    pi_rd("clr_no_recount", 3, 5, 8'd0);
    m2 = 1'b0; repeat (2) tick();

    // Global disable: no substitution, frozen counters, registers still writable.
    cheats_on = 1'b0;
    cpu_read(16'hA123, 8'h00, 1'b0, 8'hEA, "off", 1'b1);
    pi_rd("off_hit", 3, 5, 8'd0);
    pi_wr(6, 3, 8'h77);
    pi_rd("off_wr", 6, 3, 8'h77);
    cheats_on = 1'b1;

    // Rewrite of the replace byte mid-substitution.
    cpu_addr = 16'hA123; m2 = 1'b1; rw = 1'b1;
    repeat (DELAY + 1) tick();
    chk("rw_old", ggc_do, 8'hEA);
    pi_wr(3, 3, 8'hBB);
    chk("rw_new", ggc_do, 8'hBB);
    chk("rw_ce", {7'b0, ggc_ce}, 8'h01);
    pi_rd("rw_hit", 3, 5, 8'd1);

    // Reset mid-strobe drops substitution on the next clock.
    rst = 1'b1;
    tick();
    chk("mrst_ce", {7'b0, ggc_ce}, 8'h00);
    chk("mrst_do", ggc_do, 8'h00);
    rst = 1'b0;
    pi_rd("mrst_mode", 3, 4, 8'h00);
    pi_rd("mrst_hit", 3, 5, 8'h00);
    m2 = 1'b0; repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
